whack_input_detector: RTL and testbench
=======================================

// Module: whack_input_detector
// PURPOSE
//  Upstream stage of the LED mole driver. Turns the 10 raw slide switches into
//  debounced "whack" events and classifies each one against the lit LEDs.
//  - Hits go out as a one-hot vector (hit_LEDs) that clears the lit LEDs.
//  - Misses are counted as well, and both tallies are kept for the score display.
// PARAMETERS
//  N_SW            10     number of switches/LEDs
//  DEBOUNCE_CYCLES 50000  consecutive stable cycles before a switch change is accepted (>=1)
//  CNT_W           16     debounce counter width (2**CNT_W > DEBOUNCE_CYCLES)
//  BOTH_EDGES      1      1: any flip is a whack; 0: only a 0->1 flip is a whack
// PORTS
//  clk          in   1      system clock
//  rst          in   1      reset, asynchronous, active-high
//  SW           in   N_SW   raw switches, asynchronous to clk
//  LEDR         in   N_SW   currently lit moles, from the LED driver
//  game_active  in   1      1: classify and score events; 0: track switches silently
//  clr_score    in   1      synchronous clear of hit_count and miss_count
//  hit_LEDs     out  N_SW   one-cycle one-hot(s) of whacked lit LEDs
//  hit_pulse    out  1      one-cycle pulse; equals |hit_LEDs
//  miss_pulse   out  1      one-cycle pulse; >=1 whack landed on an unlit LED
//  hit_count    out  8      saturating hit total
//  miss_count   out  8      saturating miss total
// BEHAVIOUR
//  Reset: all outputs are 0. Sync flops, stable[], debounce counters and init
//   counter are 0, and the block enters INIT.
//  Synchroniser: two flops per bit, s1 <= SW, s2 <= s1.
//  Debounce, per bit i:
//   - If s2[i] != stable[i], cnt[i]++. Otherwise cnt[i] <= 0.
//   - When cnt[i] == DEBOUNCE_CYCLES-1 and s2[i] != stable[i]:
//     stable[i] <= s2[i], cnt[i] <= 0, and ev[i] = 1 (combinational, that cycle).
//   - ev[i] is qualified by the edge direction when BOTH_EDGES=0.
//   - A glitch shorter than DEBOUNCE_CYCLES clears cnt and produces no event.
//  States:
//   - INIT: init counter runs DEBOUNCE_CYCLES+2 cycles while stable[] absorbs
//     the switch positions held at reset. All ev are suppressed. Then -> RUN.
//   - RUN: events are processed. A reset in any state returns to INIT and
//     discards any in-flight debounce.
//  Classification (registered, 1 cycle), in RUN with game_active=1:
//   - hit_LEDs <= ev & LEDR; hit_pulse <= |(ev & LEDR);
//     miss_pulse <= |(ev & ~LEDR).
//   - LEDR is sampled on the same edge that updates stable[].
//  With game_active=0, events update stable[] only. No pulses, no counts.
//  Latency: SW change to hit_LEDs high = DEBOUNCE_CYCLES+2 rising edges,
//   counted from the first edge that samples the new SW value. Pulse width is 1 cycle.
//  Counting:
//   - hit_count += popcount(ev & LEDR) and miss_count += popcount(ev & ~LEDR),
//     updated on the same edge as the pulses.
//   - Several bits in one cycle all count. Each counter saturates at 255, no wrap.
//   - clr_score=1 forces both counters to 0 and overrides a same-cycle increment.
//     Pulses are unaffected by clr_score.
//  A hit and a miss in the same cycle assert both pulses and update both counters.
// TESTING (bench DEBOUNCE_CYCLES=4)
//  LEDR=10'h004, SW[2] 0->1 held -> hit_LEDs=10'h004 and hit_pulse for 1 cycle,
//   6 edges after sampling; hit_count=1.
//  LEDR=10'h004, SW[7] 0->1 -> miss_pulse 1 cycle, hit_LEDs=0, miss_count=1.
//  SW[2] toggled for 3 cycles then restored, repeatedly -> no pulses,
//   stable[2] unchanged.
//  LEDR=10'h201, SW[0] and SW[9] flip in the same cycle -> hit_LEDs=10'h201,
//   hit_count +2; clr_score on that edge -> counts 0.
//  300 hits -> hit_count stops at 255.
//  SW=10'h3FF held through reset, then released -> no event in INIT.
//  rst asserted mid-debounce -> outputs 0, no pulse after release.

Source files
------------

// File: rtl/whack_input_detector.sv
// Debounces the raw slide switches into whack events and scores each event
// against the lit LEDs: one-cycle hit/miss pulses plus saturating tallies.
module whack_input_detector #(
   parameter int N_SW            = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int BOTH_EDGES      = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] SW,
   input  logic [N_SW-1:0] LEDR,
   input  logic            game_active,
   input  logic            clr_score,
   output logic [N_SW-1:0] hit_LEDs,
   output logic            hit_pulse,
   output logic            miss_pulse,
   output logic [7:0]      hit_count,
   output logic [7:0]      miss_count
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W:0]   INIT_LAST = (CNT_W+1)'(DEBOUNCE_CYCLES + 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t                     state;
   logic [CNT_W:0]             init_cnt;
   logic [N_SW-1:0]            s1, s2, stable;
   logic [N_SW-1:0][CNT_W-1:0] cnt;
   logic [N_SW-1:0]            ev, hit_v, miss_v;
   logic                       score_en;

   function automatic logic [7:0] popcount(input logic [N_SW-1:0] v);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < N_SW; i++) n = n + {7'd0, v[i]};
      return n;
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   // Synchroniser and per-bit debounce; stable[] follows s2 after a full quiet run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1     <= '0;
         s2     <= '0;
         stable <= '0;
         cnt    <= '0;
      end else begin
         s1 <= SW;
         s2 <= s1;
         for (int i = 0; i < N_SW; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Events are muted in INIT so switch positions held at reset never score
   always_comb begin
      ev = '0;
      for (int i = 0; i < N_SW; i++)
         ev[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST) && ((BOTH_EDGES != 0) || s2[i]);
      if (state == INIT) ev = '0;
   end

   assign hit_v    = ev & LEDR;
   assign miss_v   = ev & ~LEDR;
   assign score_en = (state == RUN) && game_active;

   // Control FSM and registered classification outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= INIT;
         init_cnt   <= '0;
         hit_LEDs   <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            INIT: begin
               if (init_cnt == INIT_LAST) state <= RUN;
               else init_cnt <= init_cnt + (CNT_W+1)'(1);
            end
            RUN:     state <= RUN;
            default: state <= INIT;
         endcase

         hit_LEDs   <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         if (score_en) begin
            hit_LEDs   <= hit_v;
            hit_pulse  <= |hit_v;
            miss_pulse <= |miss_v;
         end

         if (clr_score) begin
            hit_count  <= '0;
            miss_count <= '0;
         end else if (score_en) begin
            hit_count  <= sat_add(hit_count, popcount(hit_v));
            miss_count <= sat_add(miss_count, popcount(miss_v));
         end
      end
   end

endmodule

// File: tb/tb_whack_input_detector.sv
// Bench for whack_input_detector: randomized and directed stimulus compared each
// cycle against a sample-history reference model of debounce, INIT and scoring.
module tb_whack_input_detector;

   localparam int N = 10;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] SW, LEDR;
   logic         game_active, clr_score;
   logic [N-1:0] hit_LEDs;
   logic         hit_pulse, miss_pulse;
   logic [7:0]   hit_count, miss_count;

   whack_input_detector #(
      .N_SW(N), .DEBOUNCE_CYCLES(D), .CNT_W(4), .BOTH_EDGES(1)
   ) dut (
      .clk(clk), .rst(rst), .SW(SW), .LEDR(LEDR), .game_active(game_active),
      .clr_score(clr_score), .hit_LEDs(hit_LEDs), .hit_pulse(hit_pulse),
      .miss_pulse(miss_pulse), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a switch whacks when its last D sampled values (ending two
   // edges back, the synchroniser delay) all differ from the accepted position.
   logic [N-1:0] hist[$];
   logic [N-1:0] m_stable     = '0;
   int           ecount       = 0;
   logic [N-1:0] exp_hit_LEDs = '0;
   logic         exp_hp       = 1'b0;
   logic         exp_mp       = 1'b0;
   logic [7:0]   exp_hc       = '0;
   logic [7:0]   exp_mc       = '0;
   logic [27:0]  obs, exp_vec;

   assign obs     = {hit_LEDs, hit_pulse, miss_pulse, hit_count, miss_count};
   assign exp_vec = {exp_hit_LEDs, exp_hp, exp_mp, exp_hc, exp_mc};

   task automatic model_step();
      logic [N-1:0] ev;
      logic         flip;
      int           t;
      if (rst) begin
         hist = {};
         repeat (D + 2) hist.push_back('0);
         m_stable = '0;
         ecount = 0;
         exp_hit_LEDs = '0;
         exp_hp = 1'b0;
         exp_mp = 1'b0;
         exp_hc = '0;
         exp_mc = '0;
      end else begin
         hist.push_back(SW);
         void'(hist.pop_front());
         ecount++;
         ev = '0;
         for (int i = 0; i < N; i++) begin
            flip = 1'b1;
            for (int k = 0; k < D; k++) if (hist[k][i] == m_stable[i]) flip = 1'b0;
            ev[i] = flip;
         end
         m_stable = m_stable ^ ev;
         if (ecount < D + 3 || !game_active) ev = '0;
         exp_hit_LEDs = ev & LEDR;
         exp_hp = |(ev & LEDR);
         exp_mp = |(ev & ~LEDR);
         if (clr_score) begin
            exp_hc = '0;
            exp_mc = '0;
         end else begin
            t = int'(exp_hc) + $countones(ev & LEDR);
            exp_hc = (t > 255) ? 8'd255 : 8'(t);
            t = int'(exp_mc) + $countones(ev & ~LEDR);
            exp_mc = (t > 255) ? 8'd255 : 8'(t);
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   task automatic test_reset();
      logic saw;
      SW = 10'h3FF; LEDR = 10'h3FF; game_active = 1'b1; clr_score = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (obs !== 28'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
      rst = 1'b0;
      saw = 1'b0;
      repeat (D + 10) begin
         @(negedge clk);
         saw = saw | hit_pulse | miss_pulse;
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL init_model: got %h want %h", obs, exp_vec); end
      end
      n_tests++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL init_no_event: got %b want 0", saw); end
   endtask

   task automatic test_hit();
      int first;
      game_active = 1'b0; SW = '0;
      repeat (D + 6) begin
         @(negedge clk);
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL silent_model: got %h want %h", obs, exp_vec); end
      end
      game_active = 1'b1; LEDR = 10'h004; SW = 10'h004;
      first = 0;
      for (int k = 1; k <= D + 4; k++) begin
         @(negedge clk);
         if (hit_pulse && first == 0) first = k;
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL hit_model: got %h want %h", obs, exp_vec); end
      end
      n_tests++;
      if (first !== D + 2) begin n_fail++; $display("FAIL hit_latency: got %0d want %0d", first, D + 2); end
      n_tests++;
      if (hit_count !== 8'd1) begin n_fail++; $display("FAIL hit_count: got %0d want 1", hit_count); end
   endtask

   task automatic test_miss();
      SW = 10'h084;
      repeat (D + 4) begin
         @(negedge clk);
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL miss_model: got %h want %h", obs, exp_vec); end
      end
      n_tests++;
      if ({miss_count, hit_count} !== {8'd1, 8'd1})
         begin n_fail++; $display("FAIL miss_count: got m%0d h%0d want m1 h1", miss_count, hit_count); end
   endtask

   task automatic test_glitch();
      repeat (6) begin
         SW[2] = 1'b0;
         repeat ($urandom_range(1, D - 1)) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL glitch_model: got %h want %h", obs, exp_vec); end
         end
         SW[2] = 1'b1;
         repeat ($urandom_range(1, 2)) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL glitch_model: got %h want %h", obs, exp_vec); end
         end
      end
      repeat (D + 3) begin
         @(negedge clk);
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL glitch_model: got %h want %h", obs, exp_vec); end
      end
      n_tests++;
      if (dut.stable[2] !== 1'b1) begin n_fail++; $display("FAIL glitch_stable: got %b want 1", dut.stable[2]); end
   endtask

   task automatic test_dual_clr();
      logic [7:0] h0;
      LEDR = 10'h201;
      for (int round = 0; round < 2; round++) begin
         h0 = hit_count;
         SW = (round == 0) ? 10'h285 : 10'h084;
         for (int k = 1; k <= D + 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL dual_model: got %h want %h", obs, exp_vec); end
            if (k == D + 2) begin
               n_tests++;
               if (round == 0 && {hit_LEDs, hit_count} !== {10'h201, h0 + 8'd2})
                  begin n_fail++; $display("FAIL dual_hit: got %h/%0d want 201/%0d", hit_LEDs, hit_count, h0 + 8'd2); end
               if (round == 1 && {hit_LEDs, hit_count, miss_count} !== {10'h201, 16'd0})
                  begin n_fail++; $display("FAIL dual_clr: got %h/%0d/%0d want 201/0/0", hit_LEDs, hit_count, miss_count); end
            end
            clr_score = (round == 1) && (k == D + 1);
         end
      end
   endtask

   task automatic test_saturation();
      LEDR = 10'h001;
      repeat (300) begin
         SW[0] = ~SW[0];
         repeat (D + 2) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_vec) begin n_fail++; $display("FAIL sat_model: got %h want %h", obs, exp_vec); end
         end
      end
      n_tests++;
      if (hit_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d want 255", hit_count); end
   endtask

   task automatic test_random();
      repeat (600) begin
         if ($urandom_range(0, 7) == 0) SW = N'($urandom);
         else if ($urandom_range(0, 3) == 0) SW[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 3) == 0) LEDR = N'($urandom);
         if ($urandom_range(0, 15) == 0) game_active = ~game_active;
         clr_score = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL random_model: got %h want %h", obs, exp_vec); end
      end
      clr_score = 1'b0;
      game_active = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic saw;
      LEDR = 10'h008; SW = '0;
      repeat (D + 4) begin
         @(negedge clk);
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL rstmid_model: got %h want %h", obs, exp_vec); end
      end
      SW = 10'h008;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (obs !== 28'd0) begin n_fail++; $display("FAIL rstmid_outputs: got %h want 0", obs); end
      rst = 1'b0;
      saw = 1'b0;
      repeat (D + 8) begin
         @(negedge clk);
         saw = saw | hit_pulse | miss_pulse;
         n_tests++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL rstmid_model: got %h want %h", obs, exp_vec); end
      end
      n_tests++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %b want 0", saw); end
   endtask

   initial begin
      rst = 1'b1; SW = '0; LEDR = '0; game_active = 1'b0; clr_score = 1'b0;
      test_reset();
      test_hit();
      test_miss();
      test_glitch();
      test_dual_clr();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
